// File: rtl/rr_grant_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_grant_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned OW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [OW-1:0] owner;
  logic          busy;
  logic          timeout;

  // Requester side: raises req, observes the grant.
  modport master (
    output req,
    input  gnt, owner, busy, timeout
  );

  // Arbiter side: samples req, drives the registered grant outputs.
  modport slave (
    input  req,
    output gnt, owner, busy, timeout
  );
endinterface

// File: rtl/rr_grant_fsm.sv
// Round-robin arbiter for one single-owner resource with bounded hold time.
// All outputs are registered and depend only on the state registers.
module rr_grant_fsm #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  rr_grant_if.slave  arb
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic [OW-1:0] sel_c;
  logic [OW-1:0] idx_c;
  logic          found_c;
  logic [OW-1:0] ptr_next_c;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    sel_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      idx_c = OW'((32'(ptr_q) + j) % N);
      if (!found_c && arb.req[idx_c]) begin
        sel_c   = idx_c;
        found_c = 1'b1;
      end
    end
  end

  // Priority moves to the requester just after the one that held the grant.
  always_comb begin
    ptr_next_c = OW'((32'(owner_q) + 32'd1) % N);
  end

  // State and registered outputs; reset wins over any grant in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: arbitrate in IDLE; release or pre-empt in GRANT.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|arb.req) begin
          state_d = GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << sel_c;
          owner_d = sel_c;
          busy_d  = 1'b1;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        if (!arb.req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_next_c;
        end else if (cnt_q == CW'(MAX_HOLD)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = ptr_next_c;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign arb.gnt     = gnt_q;
  assign arb.owner   = owner_q;
  assign arb.busy    = busy_q;
  assign arb.timeout = timeout_q;

endmodule
